// File: rtl/apb4_pkg.sv
// Shared types and constants for the APB4 requester.
// FSM encoding, protection type and strobe-width helper.
package apb4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_state_e;

  typedef logic [2:0] apb_prot_t;

  localparam apb_prot_t PROT_DEFAULT = 3'b000;

  function automatic int STRB_W(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/apb4_master.sv
// APB4 requester: one command in, SETUP/ACCESS on the bus,
// one response out, with an optional ACCESS-phase timeout.
module apb4_master
  import apb4_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [DATA_WIDTH-1:0]         cmd_wdata,
  input  logic [STRB_W(DATA_WIDTH)-1:0] cmd_strb,
  input  apb_prot_t                     cmd_prot,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          rsp_timeout,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [DATA_WIDTH-1:0]         pwdata,
  output logic [STRB_W(DATA_WIDTH)-1:0] pstrb,
  output apb_prot_t                     pprot,
  input  logic                          pready,
  input  logic [DATA_WIDTH-1:0]         prdata,
  input  logic                          pslverr
);

  localparam int SW     = STRB_W(DATA_WIDTH);
  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

  apb_state_e            state_q, state_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0]         pstrb_q, pstrb_d;
  apb_prot_t             pprot_q, pprot_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  to_q, to_d;
  logic                  timeout_hit;

  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    pprot_d  = pprot_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    to_d     = to_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d  = ST_SETUP;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pstrb_d  = cmd_write ? cmd_strb : '0;
          pprot_d  = cmd_prot;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        // A ready completer beats an expiring timeout.
        if (pready) begin
          state_d = ST_RESP;
          rdata_d = pwrite_q ? '0 : prdata;
          err_d   = pslverr;
          to_d    = 1'b0;
        end else if (timeout_hit) begin
          state_d = ST_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
          to_d    = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pprot_q  <= PROT_DEFAULT;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      pprot_q  <= pprot_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      to_q     <= to_d;
    end
  end

  if (TIMEOUT_CYCLES > 0) begin : g_to
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_ACCESS && !pready && !timeout_hit)
        cnt_d = cnt_q + CW'(1);
      else if (state_q == ST_RESP && rsp_ready)
        cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_to
    assign timeout_hit = 1'b0;
  end

  // Handshake/phase outputs decode straight from state so reset drops them at once.
  assign cmd_ready   = (state_q == ST_IDLE);
  assign psel        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable     = (state_q == ST_ACCESS);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = to_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = pprot_q;

endmodule

// File: tb/tb_apb4_master.sv
// Directed bench for apb4_master: vector table plus
// backpressure, back-to-back and mid-transfer reset sequences.
module tb_apb4_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready, pslverr;
  logic [31:0] prdata;

  logic        auto_c;
  logic        tb_pready;
  logic [31:0] tb_prdata;

  assign pready = auto_c ? 1'b1 : tb_pready;
  assign prdata = auto_c ? {paddr[15:0], 16'h5A5A} : tb_prdata;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  apb4_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .pready(pready), .prdata(prdata),
    .pslverr(pslverr)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    int          exp_cyc;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    logic [3:0]  exp_pstrb;
  } vec_t;

  vec_t vecs[7];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_xfer(input int idx, input vec_t v);
    int ncyc;
    int bad;
    @(negedge clk);
    chk($sformatf("v%0d_cmd_ready", idx), cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_write  = v.wr;
    cmd_addr   = v.addr;
    cmd_wdata  = v.wdata;
    cmd_strb   = v.strb;
    cmd_prot   = v.prot;
    rsp_ready  = 1'b0;
    tb_pready  = 1'b0;
    tb_prdata  = v.prdata;
    pslverr    = v.slverr;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk($sformatf("v%0d_setup", idx), {psel, penable}, 2'b10);
    chk($sformatf("v%0d_setup_addr", idx), paddr, v.addr);
    @(posedge clk);
    @(negedge clk);
    ncyc = 0;
    bad  = 0;
    while (psel && penable && ncyc < 40) begin
      if (paddr !== v.addr || pwrite !== v.wr || pstrb !== v.exp_pstrb ||
          pprot !== v.prot || (v.wr && pwdata !== v.wdata))
        bad++;
      tb_pready = (ncyc == v.waits);
      ncyc++;
      @(posedge clk);
      @(negedge clk);
    end
    tb_pready = 1'b0;
    chk($sformatf("v%0d_access_stable", idx), bad, 0);
    chk($sformatf("v%0d_access_cycles", idx), ncyc, v.exp_cyc);
    chk($sformatf("v%0d_rsp_valid", idx), {rsp_valid, cmd_ready, psel}, 3'b100);
    chk($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d_rsp_err", idx), rsp_err, v.exp_err);
    chk($sformatf("v%0d_rsp_timeout", idx), rsp_timeout, v.exp_to);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk($sformatf("v%0d_consumed", idx), {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int n;
    int idx;
    int nrsp;
    int hs_prev;
    int rtime[2];
    logic [31:0] rdat[2];

    rtime = '{0, 0};
    rdat  = '{32'h0, 32'h0};

    //           wr  addr       wdata         strb  prot   wt  prdata        err  cyc rdata         e  to pstrb
    vecs[0] = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 3'b000, 0, 32'hAAAA5555, 1'b0, 1, 32'h0,        1'b0, 1'b0, 4'hF};
    vecs[1] = '{1'b0, 32'h04,   32'h0,        4'hF, 3'b010, 3, 32'h12345678, 1'b0, 4, 32'h12345678, 1'b0, 1'b0, 4'h0};
    vecs[2] = '{1'b0, 32'h08,   32'h0,        4'h0, 3'b001, 0, 32'hCAFEF00D, 1'b1, 1, 32'hCAFEF00D, 1'b1, 1'b0, 4'h0};
    vecs[3] = '{1'b0, 32'h0C,   32'h0,        4'hF, 3'b000, 99, 32'h55AA55AA, 1'b0, 8, 32'h0,       1'b1, 1'b1, 4'h0};
    vecs[4] = '{1'b1, 32'h1000, 32'h01020304, 4'h3, 3'b101, 7, 32'hFFFFFFFF, 1'b0, 8, 32'h0,        1'b0, 1'b0, 4'h3};
    vecs[5] = '{1'b1, 32'h14,   32'hA5A5A5A5, 4'h8, 3'b111, 2, 32'h0,        1'b1, 3, 32'h0,        1'b1, 1'b0, 4'h8};
    vecs[6] = '{1'b1, 32'h18,   32'h77,       4'h1, 3'b000, 99, 32'h99,      1'b1, 8, 32'h0,        1'b1, 1'b1, 4'h1};

    rst       = 1'b1;
    auto_c    = 1'b0;
    tb_pready = 1'b0;
    tb_prdata = 32'h0;
    pslverr   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    cmd_strb  = 4'h0;
    cmd_prot  = 3'h0;
    rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_handshake", {cmd_ready, rsp_valid}, 2'b10);
    chk("reset_bus_ctl", {psel, penable, pwrite}, 3'b000);
    chk("reset_bus_data", {paddr, pwdata}, 64'h0);
    chk("reset_strb_prot", {pstrb, pprot}, 7'h0);
    chk("reset_rsp", {rsp_rdata, rsp_err, rsp_timeout}, 34'h0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_xfer(i, vecs[i]);

    // Response backpressure with a second command already waiting.
    auto_c    = 1'b1;
    pslverr   = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h40;
    cmd_wdata = 32'h1234;
    cmd_strb  = 4'hF;
    cmd_prot  = 3'b000;
    @(posedge clk);
    @(negedge clk);
    cmd_write = 1'b0;
    cmd_addr  = 32'h20;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("bp_reached_resp", rsp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d", k),
          {rsp_valid, cmd_ready, psel, rsp_rdata, rsp_err, rsp_timeout},
          {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0});
      if (k < 4) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    rsp_ready = 1'b1;

    idx     = 0;
    nrsp    = 0;
    hs_prev = 0;
    for (int c = 0; c < 30 && nrsp < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (hs_prev != 0) begin
        idx++;
        if (idx == 1) cmd_addr = 32'h24;
        else cmd_valid = 1'b0;
      end
      if (rsp_valid) begin
        rtime[nrsp] = cyc;
        rdat[nrsp]  = rsp_rdata;
        nrsp++;
      end
      hs_prev = (cmd_valid && cmd_ready) ? 1 : 0;
    end
    cmd_valid = 1'b0;
    chk("b2b_count", nrsp, 2);
    chk("b2b_first", rdat[0], 32'h00205A5A);
    chk("b2b_second", rdat[1], 32'h00245A5A);
    chk("b2b_period", rtime[1] - rtime[0], 4);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    auto_c    = 1'b0;

    // Reset arriving while the completer is inserting wait states.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h30;
    tb_pready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("rst_mid_pre", {psel, penable}, 2'b11);
    rst = 1'b1;
    #1;
    chk("rst_mid_drop", {psel, penable, rsp_valid}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_after", {cmd_ready, rsp_valid, psel}, 3'b100);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_rsp", {rsp_valid, psel}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb4_master.md
Name: apb4_master

Overview:
- APB4 requester (initiator) for the other end of the existing APB4 slave bridges.
- Accepts single read/write commands on a valid/ready command port and runs the APB4 SETUP/ACCESS sequence on the bus.
- Returns read data, error and timeout status on a valid/ready response port.
- Used by on-chip controllers and test harnesses to drive the CSR blocks.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and paddr.
- DATA_WIDTH, 32, data width. Legal values: 8, 16, 32. Strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, ACCESS-phase cycles before abort. 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte enables.
- cmd_prot  in  3  protection attributes, passed to pprot.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  pslverr or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_WIDTH/8  APB strobes.
- pprot  out  3  APB protection.
- pready  in  1  completer ready.
- prdata  in  DATA_WIDTH  completer read data.
- pslverr  in  1  completer error.

Behaviour:
- Reset: state IDLE; every output 0 except cmd_ready = 1; timeout counter 0. Reset mid-transfer drops psel/penable immediately and discards the transfer; no response is produced.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On handshake: register write, addr, wdata, strb, prot; go to SETUP.
  - For reads, pstrb is registered as 0 regardless of cmd_strb.
- SETUP (one cycle): psel = 1, penable = 0; go to ACCESS.
- ACCESS:
  - psel = 1, penable = 1. Bus signals stay stable until exit.
  - If pready = 1: capture prdata (reads only; 0 for writes) and pslverr into rsp_err. rsp_timeout = 0. Go to RESP.
  - Else, if TIMEOUT_CYCLES > 0: increment the counter. When the counter reaches TIMEOUT_CYCLES - 1 with pready low, go to RESP with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - pready wins over timeout in the same cycle.
- RESP:
  - psel = 0, penable = 0, rsp_valid = 1.
  - rsp_* held stable until rsp_ready.
  - On rsp_ready: go to IDLE, clear the counter.
- cmd_ready is 0 outside IDLE. There is no command buffering and only one outstanding transfer.
- Latency: command accepted at cycle T → SETUP at T+1 → ACCESS at T+2. With pready at T+2, rsp_valid rises at T+3. Each wait state adds one cycle.
- Back-to-back: with rsp_ready tied high, the next command can be accepted one cycle after RESP. Minimum period is 4 cycles per transfer.
- Bus outputs hold their last values in IDLE/RESP (psel = 0). Verification only checks them while psel = 1.
- Addresses are not alignment-checked; paddr = cmd_addr unmodified.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit.

Decomposition:
- apb4_pkg holds:
  - the FSM state enum;
  - the apb_prot_t 3-bit typedef;
  - constants PROT_DEFAULT = 3'b000 and STRB_W(DATA_WIDTH).
- No sub-module is required. The timeout counter is inline, with a generate guard for TIMEOUT_CYCLES = 0.

Test Plan:
- Write, zero wait. addr 0x10, wdata 0xDEADBEEF, strb 0xF, pready high in the first ACCESS cycle → psel at T+1, penable at T+2, rsp_valid at T+3, rsp_err = 0, rsp_rdata = 0.
- Read, 3 wait states. addr 0x04, prdata 0x12345678 with pready on the 4th ACCESS cycle → rsp_rdata = 0x12345678; pstrb = 0 throughout; paddr/pwrite stable for all ACCESS cycles.
- Slave error. Read with pslverr = 1 and pready = 1 → rsp_err = 1, rsp_timeout = 0.
- Timeout. TIMEOUT_CYCLES = 8, pready held low → exactly 8 ACCESS cycles, then psel = 0, rsp_err = 1, rsp_timeout = 1. A variant with pready rising on cycle 8 gives a normal completion.
- Response backpressure and back-to-back:
  - rsp_ready low for 5 cycles → rsp_* held stable, cmd_ready = 0, no new psel.
  - Then two queued commands complete in order, 4 cycles apart.
- Reset mid-ACCESS. Assert rst during a wait state → psel/penable drop the same cycle; after release cmd_ready = 1, rsp_valid = 0.
